// File: rtl/dmem_cell_port_if.sv
// Bundle of core-side move handshake and DMEM RD/WD <-> RF/WF bus signals.
// master is the requester's view; slave is the core/memory environment's view.
interface dmem_cell_port_if #(
  parameter int AW = 15,
  parameter int DW = 8
);
  logic          mv_req;
  logic [AW-1:0] mv_ptr;
  logic [DW-1:0] cell_wdata;
  logic          cell_dirty;
  logic          mv_ack;
  logic [DW-1:0] cell_rdata;
  logic          busy;
  logic          err;
  logic [AW-1:0] DP;
  logic [DW-1:0] WDATA;
  logic          WD;
  logic          RD;
  logic          WF;
  logic          RF;
  logic [DW-1:0] RDATA;

  modport master (
    input  mv_req, mv_ptr, cell_wdata, cell_dirty, WF, RF, RDATA,
    output mv_ack, cell_rdata, busy, err, DP, WDATA, WD, RD
  );

  modport slave (
    output mv_req, mv_ptr, cell_wdata, cell_dirty, WF, RF, RDATA,
    input  mv_ack, cell_rdata, busy, err, DP, WDATA, WD, RD
  );
endinterface

// File: rtl/dmem_cell_port.sv
// Core-side requester: on a pointer move, writes back a dirty cell, reads the
// cell at the new pointer and acknowledges the core, with a wait-state timeout.
module dmem_cell_port #(
  parameter int AW  = 15,
  parameter int DW  = 8,
  parameter int TMO = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_cell_port_if.master bus
);

  typedef enum logic [2:0] {IDLE, WR_ARM, WR_WAIT, RD_ARM, RD_WAIT, ACK} state_t;

  localparam int            CW       = $clog2(TMO);
  // Firing one count early makes a stuck strobe stay high for TMO-1 cycles.
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 2);

  state_t        state;
  logic [AW-1:0] cur_ptr;
  logic [AW-1:0] new_ptr;
  logic [DW-1:0] wbuf;
  logic [CW-1:0] tmo_cnt;
  logic          waiting;
  logic          advance;
  logic          tmo_hit;

  always_comb begin
    waiting = 1'b1;
    advance = 1'b0;
    case (state)
      WR_ARM:  advance = !bus.WF;
      WR_WAIT: advance = bus.WF;
      RD_ARM:  advance = !bus.RF && !bus.WF;
      RD_WAIT: advance = bus.RF;
      default: waiting = 1'b0;
    endcase
    tmo_hit = waiting && !advance && (tmo_cnt == TMO_LAST);
  end

  assign bus.WDATA = wbuf;

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.mv_req) new_ptr <= bus.mv_ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cur_ptr        <= '0;
      wbuf           <= '0;
      tmo_cnt        <= '0;
      bus.mv_ack     <= 1'b0;
      bus.cell_rdata <= '0;
      bus.busy       <= 1'b0;
      bus.err        <= 1'b0;
      bus.DP         <= '0;
      bus.WD         <= 1'b0;
      bus.RD         <= 1'b0;
    end else begin
      bus.mv_ack <= 1'b0;
      if (tmo_hit) begin
        // Abandon the access but keep the core's pointer view consistent.
        state          <= ACK;
        tmo_cnt        <= '0;
        bus.err        <= 1'b1;
        bus.WD         <= 1'b0;
        bus.RD         <= 1'b0;
        bus.cell_rdata <= '0;
        cur_ptr        <= new_ptr;
        bus.DP         <= new_ptr;
        bus.mv_ack     <= 1'b1;
      end else begin
        if (waiting && !advance) tmo_cnt <= tmo_cnt + 1'b1;
        case (state)
          IDLE: begin
            if (bus.mv_req) begin
              wbuf     <= bus.cell_wdata;
              tmo_cnt  <= '0;
              bus.busy <= 1'b1;
              if (bus.cell_dirty) begin
                state <= WR_ARM;
              end else if (bus.mv_ptr != cur_ptr) begin
                state <= RD_ARM;
              end else begin
                state          <= ACK;
                bus.cell_rdata <= bus.cell_wdata;
                bus.mv_ack     <= 1'b1;
              end
            end
          end
          WR_ARM: begin
            if (advance) begin
              state   <= WR_WAIT;
              tmo_cnt <= '0;
              bus.WD  <= 1'b1;
              bus.DP  <= cur_ptr;
            end
          end
          WR_WAIT: begin
            if (advance) begin
              tmo_cnt <= '0;
              bus.WD  <= 1'b0;
              if (new_ptr == cur_ptr) begin
                state          <= ACK;
                bus.cell_rdata <= wbuf;
                bus.mv_ack     <= 1'b1;
              end else begin
                state <= RD_ARM;
              end
            end
          end
          RD_ARM: begin
            if (advance) begin
              state   <= RD_WAIT;
              tmo_cnt <= '0;
              bus.RD  <= 1'b1;
              bus.DP  <= new_ptr;
            end
          end
          RD_WAIT: begin
            if (advance) begin
              state          <= ACK;
              tmo_cnt        <= '0;
              bus.RD         <= 1'b0;
              bus.cell_rdata <= bus.RDATA;
              cur_ptr        <= new_ptr;
              bus.DP         <= new_ptr;
              bus.mv_ack     <= 1'b1;
            end
          end
          ACK: begin
            state    <= IDLE;
            tmo_cnt  <= '0;
            bus.busy <= 1'b0;
            bus.DP   <= cur_ptr;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
